// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/top_full_adder.sv
// One-bit full adder cell.
// Latency: combinational, zero cycles.
// Backpressure: none; pure logic.
module top_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per clock.
// Latency: done pulses WIDTH edges after the start edge; WIDTH+1 cycles occupied.
// Backpressure: start is only honoured in IDLE; requests in SHIFT/DONE are dropped.
module serial_adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic              carry;
    logic              fa_sum;
    logic              fa_cout;
    logic              last_bit;

    assign last_bit = (cnt == LAST);

    top_full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // cout/ovf are only rewritten on the final bit, so they hold through IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
                SHIFT: begin
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    carry <= fa_cout;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    if (last_bit) begin
                        // carry register still holds the carry into the MSB here
                        cout <= fa_cout;
                        ovf  <= carry ^ fa_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with a result scoreboard.
module tb_serial_adder_ctrl;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    res_t exp_q[$];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic res_t model(input logic [7:0] aa, input logic [7:0] bb, input logic cc);
        res_t       r;
        logic [8:0] t;
        t      = {1'b0, aa} + {1'b0, bb} + {8'd0, cc};
        r.sum  = t[7:0];
        r.cout = t[8];
        r.ovf  = (aa[7] == bb[7]) && (t[7] != aa[7]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pops the scoreboard and compares the result outputs (call in the done cycle).
    task automatic chk_result(input string tag, output res_t e);
        e = '0;
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " sum"},  32'(sum),  32'(e.sum));
            chk({tag, " cout"}, 32'(cout), 32'(e.cout));
            chk({tag, " ovf"},  32'(ovf),  32'(e.ovf));
        end
    endtask

    // Issues one addition from IDLE and checks latency, busy span, result and hold.
    task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                          input string tag);
        int   n;
        int   busy_n;
        res_t e;
        a = aa; b = bb; cin = cc; start = 1'b1;
        exp_q.push_back(model(aa, bb, cc));
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        n = 0; busy_n = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " done_seen"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'd8);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'd8);
        chk({tag, " busy_with_done"}, 32'(busy), 32'd0);
        chk_result(tag, e);
        @(posedge clk); #1;
        chk({tag, " done_single"}, 32'(done), 32'd0);
        chk({tag, " sum_hold"}, 32'(sum), 32'(e.sum));
        chk({tag, " cout_hold"}, 32'(cout), 32'(e.cout));
    endtask

    initial begin
        int   d0;
        int   n;
        int   t_done[$];
        res_t e;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum",  32'(sum),  32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        chk("rst ovf",  32'(ovf),  32'd0);
        #8 rst_n = 1'b1;

        // First start lands on the first edge after reset release.
        run_op(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");

        // start re-pulsed in SHIFT and in DONE must be dropped.
        d0 = done_cnt;
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        exp_q.push_back(model(8'h12, 8'h34, 1'b1));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("ignore done_seen", 32'(done), 32'd1);
        chk("ignore latency", 32'(n + 4), 32'd8);
        chk_result("ignore", e);
        a = 8'hF0; b = 8'hF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignore idle_after_done", 32'(busy), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("ignore no_restart", 32'(busy), 32'd0);
        chk("ignore one_done", 32'(done_cnt - d0), 32'd1);
        chk("ignore sum_hold", 32'(sum), 32'h47);

        // Reset at bit 4 aborts the addition with no done pulse.
        a = 8'h37; b = 8'h21; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum",  32'(sum),  32'd0);
        chk("abort cout", 32'(cout), 32'd0);
        chk("abort ovf",  32'(ovf),  32'd0);
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("abort no_done", 32'(done_cnt - d0), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, "after_abort");

        // start held high: back-to-back additions, 10-cycle done period
        // (8 SHIFT + 1 DONE + 1 IDLE), busy low in the IDLE between them.
        a = 8'h81; b = 8'h80; cin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back(model(8'h81, 8'h80, 1'b0));
        n = 0;
        while (t_done.size() < 3 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) begin
                t_done.push_back(cyc);
                chk_result("b2b", e);
                if (t_done.size() == 3) start = 1'b0;
                @(posedge clk); #1;
                n++;
                chk("b2b idle_gap busy", 32'(busy), 32'd0);
                chk("b2b idle_gap done", 32'(done), 32'd0);
            end
        end
        chk("b2b pulses", 32'(t_done.size()), 32'd3);
        if (t_done.size() == 3) begin
            chk("b2b period1", 32'(t_done[1] - t_done[0]), 32'd10);
            chk("b2b period2", 32'(t_done[2] - t_done[1]), 32'd10);
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("b2b stopped", 32'(busy), 32'd0);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
